// File: rtl/regfile_pkg.sv
// Shared defaults, clear-sequencer state encoding and packed-port slicing helper
// for the regfile_stack block.
package regfile_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_REG_AW   = 8;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_STACK_AW = 10;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  // Low bit of element idx in a flat packed bus of width-wide elements.
  function automatic int port_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/stack_lifo.sv
// Hardware LIFO: word memory, occupancy counter, full/empty flags, sticky
// overflow/underflow and an asynchronous top-of-stack read.
module stack_lifo
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int STACK_AW = DEF_STACK_AW
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic [DATA_W-1:0]   push_data,
  input  logic                err_clr,
  output logic [DATA_W-1:0]   top,
  output logic [STACK_AW:0]   sp,
  output logic                empty,
  output logic                full,
  output logic                ovf,
  output logic                unf
);

  localparam int                DEPTH   = 2 ** STACK_AW;
  localparam logic [STACK_AW:0] SP_FULL = (STACK_AW + 1)'(DEPTH);
  localparam logic [STACK_AW:0] SP_ONE  = (STACK_AW + 1)'(1);
  localparam logic [STACK_AW-1:0] IDX_ONE = STACK_AW'(1);

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [STACK_AW-1:0] top_idx;
  logic [STACK_AW-1:0] wr_idx;
  logic                mem_we;
  logic                sp_inc;
  logic                sp_dec;
  logic                ovf_set;
  logic                unf_set;

  assign empty   = (sp == '0);
  assign full    = (sp == SP_FULL);
  assign top_idx = sp[STACK_AW-1:0] - IDX_ONE;
  assign top     = empty ? '0 : mem[top_idx];

  // Full only blocks a plain push; push+pop on a full stack replaces the top.
  always_comb begin
    mem_we  = 1'b0;
    wr_idx  = sp[STACK_AW-1:0];
    sp_inc  = 1'b0;
    sp_dec  = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case ({push, pop})
      2'b10: begin
        if (full) begin
          ovf_set = 1'b1;
        end else begin
          mem_we = 1'b1;
          sp_inc = 1'b1;
        end
      end
      2'b01: begin
        if (empty) begin
          unf_set = 1'b1;
        end else begin
          sp_dec = 1'b1;
        end
      end
      2'b11: begin
        mem_we = 1'b1;
        if (empty) begin
          sp_inc = 1'b1;
        end else begin
          wr_idx = top_idx;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sp  <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (sp_inc) begin
        sp <= sp + SP_ONE;
      end else if (sp_dec) begin
        sp <= sp - SP_ONE;
      end
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (err_clr) begin
        ovf <= 1'b0;
      end
      if (unf_set) begin
        unf <= 1'b1;
      end else if (err_clr) begin
        unf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we && !reset) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/regfile_stack.sv
// Register file (r0 hard-wired zero, write-to-read bypass) plus LIFO stack.
// Optional REGFILE_CLEAR_EN adds a post-reset sequencer that zeroes every register.
module regfile_stack
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int REG_AW   = DEF_REG_AW,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int STACK_AW = DEF_STACK_AW
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_RD*REG_AW-1:0]   ra,
  output logic [NUM_RD*DATA_W-1:0]   rav,
  input  logic [REG_AW-1:0]          wa,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       rw,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          push_data,
  output logic [DATA_W-1:0]          top,
  output logic [STACK_AW:0]          sp,
  output logic                       empty,
  output logic                       full,
  output logic                       ovf,
  output logic                       unf,
  input  logic                       err_clr,
  output logic                       busy
);

  localparam int NUM_REGS = 2 ** REG_AW;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              reg_we;
  logic [REG_AW-1:0] reg_wa;
  logic [DATA_W-1:0] reg_wd;
  logic              push_g;
  logic              pop_g;

`ifdef REGFILE_CLEAR_EN
  // state | meaning
  // IDLE  | normal operation
  // CLEAR | zeroing r1..r(2**REG_AW-1), one register per cycle, ports blocked
  localparam logic [0:0]        IDLE      = ST_IDLE;
  localparam logic [0:0]        CLEAR     = ST_CLEAR;
  localparam logic [REG_AW-1:0] CLR_FIRST = REG_AW'(1);
  localparam logic [REG_AW-1:0] CLR_LAST  = '1;

  logic [0:0]        clr_state;
  logic [REG_AW-1:0] clr_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      clr_state <= CLEAR;
      clr_cnt   <= CLR_FIRST;
    end else if (clr_state == CLEAR) begin
      clr_cnt <= clr_cnt + CLR_FIRST;
      if (clr_cnt == CLR_LAST) begin
        clr_state <= IDLE;
      end
    end
  end

  assign busy = (clr_state == CLEAR);

  always_comb begin
    reg_we = rw && (wa != '0) && !busy && !reset;
    reg_wa = wa;
    reg_wd = wdata;
    if (busy && !reset) begin
      reg_we = 1'b1;
      reg_wa = clr_cnt;
      reg_wd = '0;
    end
  end
`else
  assign busy = 1'b0;

  always_comb begin
    reg_we = rw && (wa != '0) && !reset;
    reg_wa = wa;
    reg_wd = wdata;
  end
`endif

  always_ff @(posedge clock) begin
    if (reg_we) begin
      regs[reg_wa] <= reg_wd;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [REG_AW-1:0] addr;
    assign addr = ra[port_lo(i, REG_AW) +: REG_AW];
    assign rav[port_lo(i, DATA_W) +: DATA_W] =
      (busy || addr == '0)  ? '0    :
      (rw && wa == addr)    ? wdata :
                              regs[addr];
  end

  assign push_g = push && !busy;
  assign pop_g  = pop && !busy;

  stack_lifo #(
    .DATA_W   (DATA_W),
    .STACK_AW (STACK_AW)
  ) u_stack (
    .clock     (clock),
    .reset     (reset),
    .push      (push_g),
    .pop       (pop_g),
    .push_data (push_data),
    .err_clr   (err_clr),
    .top       (top),
    .sp        (sp),
    .empty     (empty),
    .full      (full),
    .ovf       (ovf),
    .unf       (unf)
  );

endmodule

// File: tb/tb_regfile_stack.sv
// Directed vector bench for regfile_stack (REG_AW=4, STACK_AW=2); the clear
// sequencer sequences run only when REGFILE_CLEAR_EN is defined.
module tb_regfile_stack;

  localparam int DW  = 32;
  localparam int RAW = 4;
  localparam int NRD = 2;
  localparam int SAW = 2;

  logic               clock = 1'b0;
  logic               reset;
  logic [NRD*RAW-1:0] ra;
  logic [NRD*DW-1:0]  rav;
  logic [RAW-1:0]     wa;
  logic [DW-1:0]      wdata;
  logic               rw;
  logic               push;
  logic               pop;
  logic [DW-1:0]      push_data;
  logic [DW-1:0]      top;
  logic [SAW:0]       sp;
  logic               empty;
  logic               full;
  logic               ovf;
  logic               unf;
  logic               err_clr;
  logic               busy;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  regfile_stack #(
    .DATA_W   (DW),
    .REG_AW   (RAW),
    .NUM_RD   (NRD),
    .STACK_AW (SAW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .ra        (ra),
    .rav       (rav),
    .wa        (wa),
    .wdata     (wdata),
    .rw        (rw),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .top       (top),
    .sp        (sp),
    .empty     (empty),
    .full      (full),
    .ovf       (ovf),
    .unf       (unf),
    .err_clr   (err_clr),
    .busy      (busy)
  );

  typedef struct {
    logic           rw;
    logic [RAW-1:0] wa;
    logic [DW-1:0]  wd;
    logic [RAW-1:0] ra0;
    logic [RAW-1:0] ra1;
    logic           push;
    logic           pop;
    logic [DW-1:0]  pd;
    logic           clr;
    logic [DW-1:0]  e_rav0;
    logic [DW-1:0]  e_rav1;
    logic [SAW:0]   e_sp;
    logic [DW-1:0]  e_top;
    logic           e_empty;
    logic           e_full;
    logic           e_ovf;
    logic           e_unf;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    rw = 1'b0; wa = '0; wdata = '0; ra = '0;
    push = 1'b0; pop = 1'b0; push_data = '0; err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    //          rw wa wd            ra0 ra1 pu po pd  clr rav0          rav1          sp top em fu ov un
    vecs[0]  = '{1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0,  0, 32'h0,        32'h0,        0, 0,  1, 0, 0, 0};
    vecs[1]  = '{1, 5, 32'h12345678, 0, 0, 0, 0, 0,  0, 32'h0,        32'h0,        0, 0,  1, 0, 0, 0};
    vecs[2]  = '{0, 0, 32'h0,        0, 5, 1, 0, 1,  0, 32'h0,        32'h12345678, 1, 1,  0, 0, 0, 0};
    vecs[3]  = '{1, 7, 32'hCAFE0001, 7, 5, 1, 0, 2,  0, 32'hCAFE0001, 32'h12345678, 2, 2,  0, 0, 0, 0};
    vecs[4]  = '{0, 0, 32'h0,        7, 7, 1, 0, 3,  0, 32'hCAFE0001, 32'hCAFE0001, 3, 3,  0, 0, 0, 0};
    vecs[5]  = '{1, 5, 32'h0000AAAA, 5, 7, 1, 0, 4,  0, 32'h0000AAAA, 32'hCAFE0001, 4, 4,  0, 1, 0, 0};
    vecs[6]  = '{0, 0, 32'h0,        5, 0, 1, 0, 5,  0, 32'h0000AAAA, 32'h0,        4, 4,  0, 1, 1, 0};
    vecs[7]  = '{0, 0, 32'h0,        0, 0, 1, 0, 6,  1, 32'h0,        32'h0,        4, 4,  0, 1, 1, 0};
    vecs[8]  = '{0, 0, 32'h0,        0, 0, 0, 0, 0,  1, 32'h0,        32'h0,        4, 4,  0, 1, 0, 0};
    vecs[9]  = '{0, 0, 32'h0,        0, 0, 1, 1, 99, 0, 32'h0,        32'h0,        4, 99, 0, 1, 0, 0};
    vecs[10] = '{0, 0, 32'h0,        0, 0, 0, 1, 0,  0, 32'h0,        32'h0,        3, 3,  0, 0, 0, 0};
    vecs[11] = '{0, 0, 32'h0,        0, 0, 0, 1, 0,  0, 32'h0,        32'h0,        2, 2,  0, 0, 0, 0};
    vecs[12] = '{0, 0, 32'h0,        0, 0, 1, 1, 20, 0, 32'h0,        32'h0,        2, 20, 0, 0, 0, 0};
    vecs[13] = '{0, 0, 32'h0,        0, 0, 0, 1, 0,  0, 32'h0,        32'h0,        1, 1,  0, 0, 0, 0};
    vecs[14] = '{0, 0, 32'h0,        0, 0, 0, 1, 0,  0, 32'h0,        32'h0,        0, 0,  1, 0, 0, 0};
    vecs[15] = '{0, 0, 32'h0,        0, 0, 0, 1, 0,  0, 32'h0,        32'h0,        0, 0,  1, 0, 0, 1};
    vecs[16] = '{0, 0, 32'h0,        0, 0, 0, 0, 0,  1, 32'h0,        32'h0,        0, 0,  1, 0, 0, 0};
    vecs[17] = '{0, 0, 32'h0,        0, 0, 1, 1, 7,  0, 32'h0,        32'h0,        1, 7,  0, 0, 0, 0};
    vecs[18] = '{0, 0, 32'h0,        0, 0, 0, 1, 0,  0, 32'h0,        32'h0,        0, 0,  1, 0, 0, 0};
    vecs[19] = '{0, 0, 32'h0,        0, 0, 0, 1, 0,  1, 32'h0,        32'h0,        0, 0,  1, 0, 0, 1};

    // Reset with a push pending: the push must be dropped.
    idle_inputs();
    reset = 1'b1;
    push = 1'b1;
    push_data = 32'h11;
    repeat (3) tick();
    reset = 1'b0;
    push = 1'b0;
    chk("rst_sp", 32'(sp), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_unf", 32'(unf), 32'd0);
    chk("rst_top", top, 32'd0);
`ifdef REGFILE_CLEAR_EN
    chk("rst_busy", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    chk("init_clear_cycles", 32'(n), 32'd15);
`else
    chk("rst_busy", 32'(busy), 32'd0);
`endif

    for (int i = 0; i < NV; i++) begin
      rw = vecs[i].rw;
      wa = vecs[i].wa;
      wdata = vecs[i].wd;
      ra = {vecs[i].ra1, vecs[i].ra0};
      push = vecs[i].push;
      pop = vecs[i].pop;
      push_data = vecs[i].pd;
      err_clr = vecs[i].clr;
      #4;
      chk($sformatf("v%0d_rav0", i), rav[31:0], vecs[i].e_rav0);
      chk($sformatf("v%0d_rav1", i), rav[63:32], vecs[i].e_rav1);
      tick();
      chk($sformatf("v%0d_sp", i), 32'(sp), 32'(vecs[i].e_sp));
      chk($sformatf("v%0d_top", i), top, vecs[i].e_top);
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].e_empty));
      chk($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].e_full));
      chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].e_ovf));
      chk($sformatf("v%0d_unf", i), 32'(unf), 32'(vecs[i].e_unf));
    end
    idle_inputs();

`ifdef REGFILE_CLEAR_EN
    rw = 1'b1; wa = 4'd3; wdata = 32'd5;
    tick();
    rw = 1'b0;
    ra = {4'd0, 4'd3};
    #4;
    chk("preload_r3", rav[31:0], 32'd5);
    tick();
`endif

    // Mid-operation reset: one good push, then a push during reset is dropped.
    push = 1'b1; push_data = 32'd55;
    tick();
    chk("pre_rst_sp", 32'(sp), 32'd1);
    chk("pre_rst_top", top, 32'd55);
    reset = 1'b1; push_data = 32'd66;
    tick();
    reset = 1'b0; push = 1'b0;
    chk("midrst_sp", 32'(sp), 32'd0);
    chk("midrst_top", top, 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);

`ifdef REGFILE_CLEAR_EN
    // Clear cycle 1: write, pop and bypass must all be suppressed.
    rw = 1'b1; wa = 4'd3; wdata = 32'd77; pop = 1'b1;
    ra = {4'd5, 4'd3};
    chk("clr_busy", 32'(busy), 32'd1);
    #4;
    chk("clr_rav0_bypass", rav[31:0], 32'd0);
    chk("clr_rav1", rav[63:32], 32'd0);
    #1;
    repeat (5) tick();
    chk("clr_busy_cycle6", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    rw = 1'b0; pop = 1'b0;
    chk("restart_clear_cycles", 32'(n), 32'd15);
    chk("clr_unf", 32'(unf), 32'd0);
    chk("clr_sp", 32'(sp), 32'd0);
    #4;
    chk("clr_r3", rav[31:0], 32'd0);
    chk("clr_r5", rav[63:32], 32'd0);
`else
    chk("busy_tied", 32'(busy), 32'd0);
    ra = {4'd5, 4'd7};
    #4;
    chk("keep_r7", rav[31:0], 32'hCAFE0001);
    chk("keep_r5", rav[63:32], 32'h0000AAAA);
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
